conv_seq_ctrl: RTL and testbench

// - Parametrised multi-image convolution sequencer; successor to the fixed 3x3 controller.
// - Walks the input SRAM image list until the END_MARK sentinel, reading each image header
//   and reading the KxK kernel from wmem (K set at run time, K <= KMAX).
// - Drives datapath strobes (row load, column advance, conv valid, row commit) and owns every address.
// - Sits between the top-level run/busy handshake and the convolution datapath.

---
 rtl/conv_seq_if.sv | 43 ++++
 rtl/conv_seq_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_conv_seq_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_seq_if.sv
// ---------------------------------------------------------------------------
// conv_seq_if
// Bundle of the run/busy handshake, the two memory read ports and the
// datapath strobes exchanged between conv_seq_ctrl and its surroundings.
//   master : the sequencer (drives addresses, latched dims and strobes)
//   slave  : the environment (drives dut_run and both read-data buses)
// ---------------------------------------------------------------------------
interface conv_seq_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int DIM_W  = 8
) ();
  logic              dut_run;
  logic              dut_busy;
  logic [ADDR_W-1:0] sram_raddr;
  logic [DATA_W-1:0] sram_rdata;
  logic [ADDR_W-1:0] wmem_raddr;
  logic [DATA_W-1:0] wmem_rdata;
  logic [DIM_W-1:0]  in_nrows;
  logic [DIM_W-1:0]  in_ncols;
  logic [DIM_W-1:0]  k_dim;
  logic              wgt_load;
  logic              row_load;
  logic              col_adv;
  logic              conv_valid;
  logic              out_row_commit;
  logic [ADDR_W-1:0] out_waddr;
  logic              cfg_err;

  modport master (
    input  dut_run, sram_rdata, wmem_rdata,
    output dut_busy, sram_raddr, wmem_raddr, in_nrows, in_ncols, k_dim,
           wgt_load, row_load, col_adv, conv_valid, out_row_commit,
           out_waddr, cfg_err
  );

  modport slave (
    output dut_run, sram_rdata, wmem_rdata,
    input  dut_busy, sram_raddr, wmem_raddr, in_nrows, in_ncols, k_dim,
           wgt_load, row_load, col_adv, conv_valid, out_row_commit,
           out_waddr, cfg_err
  );
endinterface

// File: rtl/conv_seq_ctrl.sv
// ---------------------------------------------------------------------------
// conv_seq_ctrl
// Multi-image convolution sequencer. Walks the image list in the input SRAM
// until the END_MARK header, reads each header and the KxK kernel (K and one
// weight word from wmem), validates the header, then primes K input rows and
// sweeps the window across every output row, issuing every memory address
// and every datapath strobe itself.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high
//   bus         conv_seq_if.master: dut_run/dut_busy handshake, SRAM and wmem
//               read ports (data valid RD_LAT cycles after the address),
//               latched in_nrows/in_ncols/k_dim, strobes wgt_load, row_load,
//               col_adv, conv_valid, out_row_commit, out_waddr, cfg_err
//   perf_cycles / perf_pixels  (only with CONV_SEQ_PERF_EN defined)
//               saturating busy-cycle and output-pixel counters, cleared on
//               run accept
//
// Build option: define CONV_SEQ_PERF_EN to add the performance counters.
// ---------------------------------------------------------------------------
module conv_seq_ctrl #(
  parameter int                ADDR_W   = 12,
  parameter int                DATA_W   = 16,
  parameter int                DIM_W    = 8,
  parameter int                KMAX     = 3,
  parameter int                RD_LAT   = 2,
  parameter logic [DATA_W-1:0] END_MARK = 'h00FF
) (
  input  logic        clk,
  input  logic        reset,
  conv_seq_if.master  bus
`ifdef CONV_SEQ_PERF_EN
  ,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_pixels
`endif
);

  localparam int LAT_W = $clog2(RD_LAT + 1);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_HDR_R   = 4'd1;
  localparam logic [3:0] S_HDR_C   = 4'd2;
  localparam logic [3:0] S_WGT_K   = 4'd3;
  localparam logic [3:0] S_WGT_D   = 4'd4;
  localparam logic [3:0] S_CHECK   = 4'd5;
  localparam logic [3:0] S_PRIME   = 4'd6;
  localparam logic [3:0] S_SWEEP   = 4'd7;
  localparam logic [3:0] S_ROW_END = 4'd8;
  localparam logic [3:0] S_LOAD_W  = 4'd9;
  localparam logic [3:0] S_DONE    = 4'd10;

  logic [3:0]        state;
  logic [ADDR_W-1:0] base_addr;   // header address of the current image
  logic [LAT_W-1:0]  lat_cnt;     // cycles since a header/weight address issue
  logic [DIM_W-1:0]  iss_cnt;     // priming rows issued
  logic [DIM_W-1:0]  ld_cnt;      // input rows loaded for this image
  logic [DIM_W-1:0]  col_cnt;     // sweep position within the output row
  logic [DIM_W-1:0]  orow_cnt;    // output rows committed for this image
  logic [RD_LAT-1:0] row_pipe;    // one bit per row read in flight

  logic              hdr_state;
  logic              capture;
  logic              row_issue;
  logic              illegal;
  logic              last_col;
  logic              last_row;
  logic [ADDR_W-1:0] next_base;

  // NOTE: every combinational output is assigned on every path from
  // registered state only, so no latch can be inferred.
  always_comb begin
    hdr_state = (state == S_HDR_R) || (state == S_HDR_C) ||
                (state == S_WGT_K) || (state == S_WGT_D);
    capture   = hdr_state && (lat_cnt == LAT_W'(RD_LAT));
    illegal   = (bus.k_dim == '0) || (bus.k_dim > DIM_W'(KMAX)) ||
                (bus.in_nrows < bus.k_dim) || (bus.in_ncols < bus.k_dim) ||
                (bus.in_ncols > DIM_W'(DATA_W));
    last_col  = (col_cnt == bus.in_ncols - bus.k_dim);
    last_row  = (orow_cnt == bus.in_nrows - bus.k_dim);
    // Row reads are issued K times back to back while priming, then once
    // per finished output row except after the last one.
    row_issue = ((state == S_PRIME) && (iss_cnt < bus.k_dim)) ||
                ((state == S_ROW_END) && !last_row);
    next_base = base_addr + ADDR_W'(2) + ADDR_W'(bus.in_nrows);
  end

  assign bus.row_load       = row_pipe[RD_LAT-1];
  assign bus.wgt_load       = (state == S_WGT_D) && capture;
  assign bus.conv_valid     = (state == S_SWEEP);
  assign bus.col_adv        = (state == S_SWEEP) && !last_col;
  assign bus.out_row_commit = (state == S_ROW_END);
  assign bus.cfg_err        = (state == S_CHECK) && illegal;

  // NOTE: all state updates use non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      base_addr      <= '0;
      lat_cnt        <= '0;
      iss_cnt        <= '0;
      ld_cnt         <= '0;
      col_cnt        <= '0;
      orow_cnt       <= '0;
      row_pipe       <= '0;
      bus.dut_busy   <= 1'b0;
      bus.sram_raddr <= '0;
      bus.wmem_raddr <= '0;
      bus.in_nrows   <= '0;
      bus.in_ncols   <= '0;
      bus.k_dim      <= '0;
      bus.out_waddr  <= '0;
    end else begin
      row_pipe <= (row_pipe << 1) | RD_LAT'(row_issue);
      lat_cnt  <= (hdr_state && !capture) ? lat_cnt + LAT_W'(1) : '0;

      case (state)
        S_IDLE: begin
          if (bus.dut_run) begin
            bus.dut_busy   <= 1'b1;
            base_addr      <= '0;
            bus.out_waddr  <= '0;
            bus.sram_raddr <= '0;
            state          <= S_HDR_R;
          end
        end
        S_HDR_R: begin
          if (capture) begin
            if (bus.sram_rdata == END_MARK) begin
              state <= S_DONE;
            end else begin
              bus.in_nrows   <= bus.sram_rdata[DIM_W-1:0];
              bus.sram_raddr <= base_addr + ADDR_W'(1);
              state          <= S_HDR_C;
            end
          end
        end
        S_HDR_C: begin
          if (capture) begin
            bus.in_ncols   <= bus.sram_rdata[DIM_W-1:0];
            bus.wmem_raddr <= '0;
            state          <= S_WGT_K;
          end
        end
        S_WGT_K: begin
          if (capture) begin
            bus.k_dim      <= bus.wmem_rdata[DIM_W-1:0];
            bus.wmem_raddr <= ADDR_W'(1);
            state          <= S_WGT_D;
          end
        end
        S_WGT_D: begin
          if (capture) state <= S_CHECK;
        end
        S_CHECK: begin
          if (illegal) begin
            base_addr      <= next_base;
            bus.sram_raddr <= next_base;
            state          <= S_HDR_R;
          end else begin
            bus.sram_raddr <= base_addr + ADDR_W'(2);
            iss_cnt        <= '0;
            ld_cnt         <= '0;
            col_cnt        <= '0;
            orow_cnt       <= '0;
            state          <= S_PRIME;
          end
        end
        S_PRIME: begin
          // After the K-th issue the address already points at the next row.
          if (iss_cnt < bus.k_dim) begin
            iss_cnt        <= iss_cnt + DIM_W'(1);
            bus.sram_raddr <= bus.sram_raddr + ADDR_W'(1);
          end
          if (bus.row_load) begin
            ld_cnt <= ld_cnt + DIM_W'(1);
            if (ld_cnt == bus.k_dim - DIM_W'(1)) state <= S_SWEEP;
          end
        end
        S_SWEEP: begin
          if (last_col) begin
            col_cnt <= '0;
            state   <= S_ROW_END;
          end else begin
            col_cnt <= col_cnt + DIM_W'(1);
          end
        end
        S_ROW_END: begin
          bus.out_waddr <= bus.out_waddr + ADDR_W'(1);
          orow_cnt      <= orow_cnt + DIM_W'(1);
          if (last_row) begin
            base_addr      <= next_base;
            bus.sram_raddr <= next_base;
            state          <= S_HDR_R;
          end else begin
            bus.sram_raddr <= bus.sram_raddr + ADDR_W'(1);
            state          <= S_LOAD_W;
          end
        end
        S_LOAD_W: begin
          if (bus.row_load) begin
            ld_cnt <= ld_cnt + DIM_W'(1);
            state  <= S_SWEEP;
          end
        end
        S_DONE: begin
          bus.dut_busy <= 1'b0;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CONV_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cycles <= '0;
      perf_pixels <= '0;
    end else if ((state == S_IDLE) && bus.dut_run) begin
      perf_cycles <= '0;
      perf_pixels <= '0;
    end else begin
      if (bus.dut_busy && (perf_cycles != '1)) perf_cycles <= perf_cycles + 32'd1;
      if (bus.conv_valid && (perf_pixels != '1)) perf_pixels <= perf_pixels + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_conv_seq_ctrl
// Bench for conv_seq_ctrl: behavioural SRAM/wmem with RD_LAT read latency,
// image lists built from tables or $urandom, and a closed-form reference of
// the expected row loads, pixel/advance counts, commits and weight loads.
// ---------------------------------------------------------------------------
module tb_conv_seq_ctrl;
  localparam int          ADDR_W   = 12;
  localparam int          DATA_W   = 16;
  localparam int          DIM_W    = 8;
  localparam int          KMAX     = 3;
  localparam int          RD_LAT   = 2;
  localparam logic [15:0] END_MARK = 16'h00FF;
  localparam int          MAXI     = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  conv_seq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIM_W(DIM_W)) bus ();

`ifdef CONV_SEQ_PERF_EN
  logic [31:0] perf_cycles;
  logic [31:0] perf_pixels;
`endif

  conv_seq_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIM_W(DIM_W),
    .KMAX(KMAX), .RD_LAT(RD_LAT), .END_MARK(END_MARK)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef CONV_SEQ_PERF_EN
    ,
    .perf_cycles(perf_cycles),
    .perf_pixels(perf_pixels)
`endif
  );

  // Memories with RD_LAT cycles from address to data.
  logic [15:0] sram [4096];
  logic [15:0] wmem [2];
  logic [15:0] s_pipe [RD_LAT];
  logic [15:0] w_pipe [RD_LAT];

  always @(posedge clk) begin
    s_pipe[0] <= sram[bus.sram_raddr];
    w_pipe[0] <= wmem[bus.wmem_raddr[0]];
    for (int i = 1; i < RD_LAT; i++) begin
      s_pipe[i] <= s_pipe[i-1];
      w_pipe[i] <= w_pipe[i-1];
    end
  end
  assign bus.sram_rdata = s_pipe[RD_LAT-1];
  assign bus.wmem_rdata = w_pipe[RD_LAT-1];

  // Image list description
  int          n_img;
  int          img_nr [MAXI];
  int          img_nc [MAXI];
  int          img_k  [MAXI];
  logic [15:0] img_w  [MAXI];
  logic [15:0] row_seed;

  // Expected and observed activity of one run
  logic [15:0] exp_rows[$], got_rows[$];
  logic [15:0] exp_wgt[$],  got_wgt[$];
  logic [35:0] exp_cm[$],   got_cm[$];
  int exp_cv, exp_ca, exp_ce;
  int got_cv, got_ca, got_ce, got_busy;

  int checks = 0;
  int errors = 0;

  function automatic logic [73:0] all_outs();
    return {bus.dut_busy, bus.sram_raddr, bus.wmem_raddr, bus.in_nrows,
            bus.in_ncols, bus.k_dim, bus.wgt_load, bus.row_load, bus.col_adv,
            bus.conv_valid, bus.out_row_commit, bus.out_waddr, bus.cfg_err};
  endfunction

  // Lay the list out in SRAM and derive the expected results directly from
  // the image dimensions.
  task automatic build_list();
    int a;
    int wa;
    bit legal;
    for (int i = 0; i < 4096; i++) sram[i] = 16'h0000;
    exp_rows.delete(); exp_wgt.delete(); exp_cm.delete();
    exp_cv = 0; exp_ca = 0; exp_ce = 0;
    a  = 0;
    wa = 0;
    for (int i = 0; i < n_img; i++) begin
      sram[a]   = 16'(img_nr[i]);
      sram[a+1] = 16'(img_nc[i]);
      for (int r = 0; r < img_nr[i]; r++)
        sram[a+2+r] = (row_seed != 16'h0) ? row_seed + 16'(r) : 16'($urandom);
      exp_wgt.push_back(img_w[i]);
      legal = (img_k[i] >= 1) && (img_k[i] <= KMAX) && (img_nr[i] >= img_k[i]) &&
              (img_nc[i] >= img_k[i]) && (img_nc[i] <= DATA_W);
      if (!legal) begin
        exp_ce++;
      end else begin
        for (int r = 0; r < img_nr[i]; r++) exp_rows.push_back(sram[a+2+r]);
        exp_cv += (img_nr[i] - img_k[i] + 1) * (img_nc[i] - img_k[i] + 1);
        exp_ca += (img_nr[i] - img_k[i] + 1) * (img_nc[i] - img_k[i]);
        for (int j = 0; j <= img_nr[i] - img_k[i]; j++) begin
          exp_cm.push_back({12'(wa), 8'(img_nr[i]), 8'(img_nc[i]), 8'(img_k[i])});
          wa++;
        end
      end
      a += 2 + img_nr[i];
    end
    sram[a] = END_MARK;
    wmem[0] = (n_img > 0) ? 16'(img_k[0]) : 16'h0003;
    wmem[1] = (n_img > 0) ? img_w[0] : 16'h0000;
  endtask

  // Start a run, record every strobe until dut_busy drops, swap in the next
  // image's kernel after each weight load. poke re-asserts dut_run mid-run.
  task automatic run_list(input string tag, input bit poke);
    int  widx;
    bit  seen_busy;
    bit  finished;
    got_rows.delete(); got_wgt.delete(); got_cm.delete();
    got_cv = 0; got_ca = 0; got_ce = 0; got_busy = 0;
    widx = 0; seen_busy = 0; finished = 0;
    @(negedge clk);
    bus.dut_run = 1'b1;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(negedge clk);
      bus.dut_run = poke && (cyc == 7) && bus.dut_busy;
      if (bus.dut_busy) begin
        got_busy++;
        seen_busy = 1;
      end
      if (bus.row_load)       got_rows.push_back(bus.sram_rdata);
      if (bus.conv_valid)     got_cv++;
      if (bus.col_adv)        got_ca++;
      if (bus.cfg_err)        got_ce++;
      if (bus.out_row_commit) got_cm.push_back({bus.out_waddr, bus.in_nrows, bus.in_ncols, bus.k_dim});
      if (bus.wgt_load) begin
        got_wgt.push_back(bus.wmem_rdata);
        widx++;
        if (widx < n_img) begin
          wmem[0] = 16'(img_k[widx]);
          wmem[1] = img_w[widx];
        end
      end
      if (seen_busy && !bus.dut_busy) begin
        finished = 1;
        break;
      end
    end
    bus.dut_run = 1'b0;
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL %s run_timeout got=busy still high want=busy low within 5000 cycles", tag);
    end
  endtask

  task automatic compare_run(input string tag);
    checks++;
    if (got_cv !== exp_cv) begin
      errors++; $display("FAIL %s conv_valid_count got=%0d want=%0d", tag, got_cv, exp_cv);
    end
    checks++;
    if (got_ca !== exp_ca) begin
      errors++; $display("FAIL %s col_adv_count got=%0d want=%0d", tag, got_ca, exp_ca);
    end
    checks++;
    if (got_ce !== exp_ce) begin
      errors++; $display("FAIL %s cfg_err_count got=%0d want=%0d", tag, got_ce, exp_ce);
    end
    checks++;
    if (got_rows.size() !== exp_rows.size()) begin
      errors++; $display("FAIL %s row_load_count got=%0d want=%0d", tag, got_rows.size(), exp_rows.size());
    end
    for (int i = 0; i < got_rows.size() && i < exp_rows.size(); i++) begin
      checks++;
      if (got_rows[i] !== exp_rows[i]) begin
        errors++; $display("FAIL %s row_data[%0d] got=%h want=%h", tag, i, got_rows[i], exp_rows[i]);
      end
    end
    checks++;
    if (got_cm.size() !== exp_cm.size()) begin
      errors++; $display("FAIL %s commit_count got=%0d want=%0d", tag, got_cm.size(), exp_cm.size());
    end
    for (int i = 0; i < got_cm.size() && i < exp_cm.size(); i++) begin
      checks++;
      if (got_cm[i] !== exp_cm[i]) begin
        errors++; $display("FAIL %s commit[%0d] {waddr,nr,nc,k} got=%h want=%h", tag, i, got_cm[i], exp_cm[i]);
      end
    end
    checks++;
    if (got_wgt.size() !== exp_wgt.size()) begin
      errors++; $display("FAIL %s wgt_load_count got=%0d want=%0d", tag, got_wgt.size(), exp_wgt.size());
    end
    for (int i = 0; i < got_wgt.size() && i < exp_wgt.size(); i++) begin
      checks++;
      if (got_wgt[i] !== exp_wgt[i]) begin
        errors++; $display("FAIL %s wgt_data[%0d] got=%h want=%h", tag, i, got_wgt[i], exp_wgt[i]);
      end
    end
    // Idle after the run: busy stays low and no strobe fires.
    @(negedge clk);
    checks++;
    if ({bus.dut_busy, bus.row_load, bus.conv_valid, bus.out_row_commit} !== 4'b0) begin
      errors++; $display("FAIL %s idle_after_run got=%b want=0000", tag,
                         {bus.dut_busy, bus.row_load, bus.conv_valid, bus.out_row_commit});
    end
  endtask

  task automatic set_img(input int i, input int nr, input int nc, input int k);
    img_nr[i] = nr; img_nc[i] = nc; img_k[i] = k; img_w[i] = 16'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.dut_run = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (all_outs() !== '0) begin
      errors++; $display("FAIL reset_outputs got=%h want=0", all_outs());
    end
    reset = 1'b0;
    bus.dut_run = 1'b0;
    @(negedge clk);
    checks++;
    if (all_outs() !== '0) begin
      errors++; $display("FAIL reset_idle_outputs got=%h want=0", all_outs());
    end
  endtask

  task automatic test_single();
    n_img = 1; set_img(0, 5, 4, 3); row_seed = 16'h000F;
    build_list();
    run_list("single", 1'b0);
`ifdef CONV_SEQ_PERF_EN
    checks++;
    if (perf_pixels !== 32'd6) begin
      errors++; $display("FAIL perf_pixels got=%0d want=6", perf_pixels);
    end
    checks++;
    if (perf_cycles !== 32'(got_busy)) begin
      errors++; $display("FAIL perf_cycles got=%0d want=%0d", perf_cycles, got_busy);
    end
`endif
    compare_run("single");
  endtask

  task automatic test_empty();
    n_img = 0; row_seed = 16'h0;
    build_list();
    run_list("empty", 1'b0);
    checks++;
    if (got_busy !== RD_LAT + 2) begin
      errors++; $display("FAIL empty_busy_cycles got=%0d want=%0d", got_busy, RD_LAT + 2);
    end
    compare_run("empty");
  endtask

  task automatic test_illegal();
    n_img = 2; set_img(0, 4, 4, 4); set_img(1, 3, 3, 3); row_seed = 16'h0;
    build_list();
    run_list("illegal", 1'b0);
    compare_run("illegal");
  endtask

  task automatic test_back_to_back();
    n_img = 2; set_img(0, 4, 4, 3); set_img(1, 4, 4, 3); row_seed = 16'h0;
    build_list();
    run_list("back_to_back", 1'b0);
    compare_run("back_to_back");
  endtask

  task automatic test_boundary();
    n_img = 3; set_img(0, 3, 16, 3); set_img(1, 2, 17, 1); set_img(2, 3, 3, 1);
    row_seed = 16'h0;
    build_list();
    run_list("boundary", 1'b1);
    compare_run("boundary");
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      n_img = $urandom_range(1, 4);
      for (int i = 0; i < n_img; i++)
        set_img(i, $urandom_range(0, 8), $urandom_range(0, 17), $urandom_range(0, 4));
      row_seed = 16'h0;
      build_list();
      run_list($sformatf("random%0d", r), 1'b1);
      compare_run($sformatf("random%0d", r));
    end
  endtask

  task automatic test_reset_mid();
    bit hit;
    n_img = 1; set_img(0, 5, 4, 3); row_seed = 16'h0;
    build_list();
    @(negedge clk);
    bus.dut_run = 1'b1;
    @(negedge clk);
    bus.dut_run = 1'b0;
    hit = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (bus.conv_valid) begin
        hit = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!hit) begin
      errors++; $display("FAIL reset_mid_sweep_reached got=no conv_valid want=conv_valid within 200 cycles");
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (all_outs() !== '0) begin
      errors++; $display("FAIL reset_mid_outputs got=%h want=0", all_outs());
    end
    build_list();
    run_list("after_reset", 1'b0);
    compare_run("after_reset");
  endtask

  initial begin
    reset = 1'b1;
    bus.dut_run = 1'b0;
    n_img = 0;
    row_seed = 16'h0;
    wmem[0] = 16'h0; wmem[1] = 16'h0;
    for (int i = 0; i < 4096; i++) sram[i] = 16'h0;
    test_reset();
    test_single();
    test_empty();
    test_illegal();
    test_back_to_back();
    test_boundary();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
